calc_seq_ctrl: RTL and testbench

Sequencing controller for the calculator datapath. It walks an SRAM address range, reads one 64-bit word per address, and presents the two 32-bit halves to the external combinational adder. It packs successive 32-bit sums into a 64-bit write buffer (lower half first, then upper) and writes each full buffer back to SRAM starting at a separate write address. It sits between the top-level start/done handshake and the single-port SRAM/adder pair.

---
 rtl/calc_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - calculator sequencer: SRAM read pairs -> adder -> packed SRAM write
// Optional active-cycle counter enabled by defining CALC_PERF_CNT_EN.
module calc_seq_ctrl #(
   parameter int DATA_W        = 32,
   parameter int MEM_WORD_SIZE = 64,
   parameter int ADDR_W        = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        read_start_addr,
   input  logic [ADDR_W-1:0]        read_end_addr,
   input  logic [ADDR_W-1:0]        write_start_addr,
   output logic                     mem_cs,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [MEM_WORD_SIZE-1:0] mem_wdata,
   input  logic [MEM_WORD_SIZE-1:0] mem_rdata,
   output logic [DATA_W-1:0]        op_a,
   output logic [DATA_W-1:0]        op_b,
   input  logic [DATA_W-1:0]        add_result,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_ADD   = 3'd2,
      S_WRITE = 3'd3,
      S_END   = 3'd4
   } state_t;

   typedef enum logic {
      LOWER = 1'b0,
      UPPER = 1'b1
   } buffer_loc_t;

   state_t                   state_q, state_d;
   buffer_loc_t              buf_loc_q, buf_loc_d;
   logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]        end_addr_q, end_addr_d;
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [MEM_WORD_SIZE-1:0] buffer_q, buffer_d;
   logic                     last_q, last_d;

   always_comb begin
      state_d    = state_q;
      buf_loc_d  = buf_loc_q;
      rd_ptr_d   = rd_ptr_q;
      end_addr_d = end_addr_q;
      wr_ptr_d   = wr_ptr_q;
      buffer_d   = buffer_q;
      last_d     = last_q;
      mem_cs     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      op_a       = '0;
      op_b       = '0;
      done       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_ptr_d   = read_start_addr;
               end_addr_d = read_end_addr;
               wr_ptr_d   = write_start_addr;
               buffer_d   = '0;
               buf_loc_d  = LOWER;
               last_d     = 1'b0;
               state_d    = S_READ;
            end
         end
         S_READ: begin
            mem_cs   = 1'b1;
            mem_addr = rd_ptr_q;
            last_d   = (rd_ptr_q == end_addr_q);
            state_d  = S_ADD;
         end
         S_ADD: begin
            op_a = mem_rdata[DATA_W-1:0];
            op_b = mem_rdata[MEM_WORD_SIZE-1:DATA_W];
            if (buf_loc_q == UPPER) begin
               buffer_d[MEM_WORD_SIZE-1:DATA_W] = add_result;
            end else begin
               buffer_d[DATA_W-1:0] = add_result;
            end
            // An odd trailing word is flushed with the upper half still zero.
            if (buf_loc_q == UPPER || last_q) begin
               state_d = S_WRITE;
            end else begin
               buf_loc_d = UPPER;
               rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
               state_d   = S_READ;
            end
         end
         S_WRITE: begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_ptr_q;
            mem_wdata = buffer_q;
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            buffer_d  = '0;
            buf_loc_d = LOWER;
            if (last_q) begin
               state_d = S_END;
            end else begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               state_d  = S_READ;
            end
         end
         S_END: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         buf_loc_q  <= LOWER;
         rd_ptr_q   <= '0;
         end_addr_q <= '0;
         wr_ptr_q   <= '0;
         buffer_q   <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_loc_q  <= buf_loc_d;
         rd_ptr_q   <= rd_ptr_d;
         end_addr_q <= end_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         buffer_q   <= buffer_d;
         last_q     <= last_d;
      end
   end

`ifdef CALC_PERF_CNT_EN
   logic [15:0] cycle_count_q, cycle_count_d;

   always_comb begin
      cycle_count_d = cycle_count_q;
      if (state_q == S_IDLE) begin
         if (start) begin
            cycle_count_d = '0;
         end
      end else if (cycle_count_q != 16'hFFFF) begin
         cycle_count_d = cycle_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count_q <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
      end
   end

   assign cycle_count = cycle_count_q;
`else
   assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed vector bench for calc_seq_ctrl with SRAM and adder models
module tb_calc_seq_ctrl;

   localparam logic [63:0] SENT = 64'hDEADBEEF_CAFEF00D;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  read_start_addr, read_end_addr, write_start_addr;
   logic        mem_cs, mem_we;
   logic [8:0]  mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [31:0] op_a, op_b, add_result;
   logic        busy, done;
   logic [15:0] cycle_count;

   logic [63:0] mem [0:511];
   logic        ld_en;
   logic [8:0]  ld_addr;
   logic [63:0] ld_data;
   int          wr_cnt, rd_cnt;
   logic [8:0]  rd_last, rd_prev;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   calc_seq_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .read_start_addr  (read_start_addr),
      .read_end_addr    (read_end_addr),
      .write_start_addr (write_start_addr),
      .mem_cs           (mem_cs),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .op_a             (op_a),
      .op_b             (op_b),
      .add_result       (add_result),
      .busy             (busy),
      .done             (done),
      .cycle_count      (cycle_count)
   );

   assign add_result = op_a + op_b;

   initial begin
      wr_cnt    = 0;
      rd_cnt    = 0;
      rd_last   = '0;
      rd_prev   = '0;
      mem_rdata = '0;
   end

   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (mem_cs && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 1;
      end else if (mem_cs) begin
         mem_rdata <= mem[mem_addr];
         rd_prev   <= rd_last;
         rd_last   <= mem_addr;
         rd_cnt    <= rd_cnt + 1;
      end
   end

   typedef struct {
      logic [8:0]  rs, re, ws;
      int          nw;
      logic [63:0] src0, src1, src2;
      int          nwr;
      logic [63:0] exp0, exp1;
      int          cyc;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic poke(input logic [8:0] a, input logic [63:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   function automatic logic [15:0] exp_cc(input int cyc);
`ifdef CALC_PERF_CNT_EN
      return 16'(cyc);
`else
      return 16'd0 + 16'(cyc - cyc);
`endif
   endfunction

   task automatic run_vec(input vec_t v, input bit poke_busy);
      int k;
      int wr0, rd0;
      bit got;
      logic [63:0] srcs [3];
      srcs[0] = v.src0; srcs[1] = v.src1; srcs[2] = v.src2;
      for (int i = 0; i < v.nw; i++) poke(v.rs + 9'(i), srcs[i]);
      poke(v.ws, SENT);
      if (v.nwr == 2) poke(v.ws + 9'd1, SENT);
      if (poke_busy) poke(9'd200, SENT);
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      @(negedge clk);
      start = 1'b1;
      read_start_addr = v.rs; read_end_addr = v.re; write_start_addr = v.ws;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      got = 1'b0;
      while (k <= 40 && !got) begin
         if (poke_busy && k == 2) begin
            start = 1'b1;
            read_start_addr = 9'd50; read_end_addr = 9'd60; write_start_addr = 9'd200;
         end else if (poke_busy && k == 3) begin
            start = 1'b0;
         end
         if (done) got = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      chk("done_latency", 64'(k), 64'(v.cyc));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("cycle_count", 64'(cycle_count), 64'(exp_cc(v.cyc)));
      chk("write_count", 64'(wr_cnt - wr0), 64'(v.nwr));
      chk("read_count", 64'(rd_cnt - rd0), 64'(v.nw));
      chk("last_read_addr", 64'(rd_last), 64'(v.re));
      chk("dest_word0", mem[v.ws], v.exp0);
      if (v.nwr == 2) chk("dest_word1", mem[v.ws + 9'd1], v.exp1);
      if (poke_busy) chk("busy_start_ignored", mem[9'd200], SENT);
   endtask

   initial begin
      int wr0;
      vecs[0] = '{rs: 9'd0, re: 9'd1, ws: 9'd16, nw: 2,
                  src0: 64'h00000003_00000005, src1: 64'h00000010_00000001, src2: 64'h0,
                  nwr: 1, exp0: 64'h00000011_00000008, exp1: 64'h0, cyc: 6};
      vecs[1] = '{rs: 9'd4, re: 9'd4, ws: 9'd8, nw: 1,
                  src0: 64'h00000002_00000002, src1: 64'h0, src2: 64'h0,
                  nwr: 1, exp0: 64'h00000000_00000004, exp1: 64'h0, cyc: 4};
      vecs[2] = '{rs: 9'd0, re: 9'd0, ws: 9'd20, nw: 1,
                  src0: 64'hFFFFFFFF_00000002, src1: 64'h0, src2: 64'h0,
                  nwr: 1, exp0: 64'h00000000_00000001, exp1: 64'h0, cyc: 4};
      vecs[3] = '{rs: 9'd511, re: 9'd0, ws: 9'd100, nw: 2,
                  src0: 64'h00000001_00000002, src1: 64'h00000005_00000006, src2: 64'h0,
                  nwr: 1, exp0: 64'h0000000B_00000003, exp1: 64'h0, cyc: 6};
      vecs[4] = '{rs: 9'd10, re: 9'd12, ws: 9'd30, nw: 3,
                  src0: 64'h00000001_00000001, src1: 64'h00000002_00000002, src2: 64'h00000007_00000008,
                  nwr: 2, exp0: 64'h00000004_00000002, exp1: 64'h00000000_0000000F, cyc: 9};

      rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      read_start_addr = '0; read_end_addr = '0; write_start_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mem_cs", 64'(mem_cs), 64'd0);
      chk("rst_cycle_count", 64'(cycle_count), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], 1'b0);
         if (i == 3) chk("wrap_first_read", 64'(rd_prev), 64'd511);
      end

      // Reset during the second word's add phase.
      poke(9'd0, vecs[0].src0);
      poke(9'd1, vecs[0].src1);
      poke(9'd16, SENT);
      wr0 = wr_cnt;
      @(negedge clk);
      start = 1'b1; read_start_addr = 9'd0; read_end_addr = 9'd1; write_start_addr = 9'd16;
      @(negedge clk);
      start = 1'b0;
      chk("read_cs", 64'(mem_cs), 64'd1);
      chk("read_we", 64'(mem_we), 64'd0);
      chk("read_op_a_zero", 64'(op_a), 64'd0);
      repeat (3) @(negedge clk);
      chk("add2_op_a", 64'(op_a), 64'h00000001);
      chk("add2_op_b", 64'(op_b), 64'h00000010);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_cs", 64'(mem_cs), 64'd0);
      chk("midrst_we", 64'(mem_we), 64'd0);
      chk("midrst_addr", 64'(mem_addr), 64'd0);
      chk("midrst_op_a", 64'(op_a), 64'd0);
      chk("midrst_cycle_count", 64'(cycle_count), 64'd0);
      repeat (3) @(negedge clk);
      chk("midrst_no_write", 64'(wr_cnt - wr0), 64'd0);
      chk("midrst_dest_kept", mem[9'd16], SENT);
      run_vec(vecs[0], 1'b0);

      run_vec(vecs[0], 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
